// File: rtl/display_ctrl_pkg.sv
// Shared constants and types for the display bus controller: register map,
// control-register bit positions and conversion parameters.
package display_ctrl_pkg;

  localparam logic [31:0] VALUE_ADDR  = 32'h0000_0148;
  localparam logic [31:0] CTRL_ADDR   = 32'h0000_014C;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0150;

  localparam int CTRL_HEX   = 0;
  localparam int CTRL_DP_LO = 1;
  localparam int CTRL_DP_HI = 4;
  localparam int CTRL_BLANK = 5;
  localparam int CTRL_W     = 6;

  localparam int DEC_MAX   = 9999;
  localparam int CONV_BITS = 14;
  localparam int SHIFT_W   = 16 + CONV_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble that is >= 5,
// then shift the whole {bcd, bin} word left by one bit.
module dabble_step
  import display_ctrl_pkg::*;
(
  input  logic [SHIFT_W-1:0] din_i,
  output logic [SHIFT_W-1:0] dout_o
);

  logic [15:0] adj;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      logic [3:0] nib;
      assign nib = din_i[CONV_BITS + gi*4 +: 4];
      assign adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign dout_o = {adj, din_i[CONV_BITS-1:0]} << 1;

endmodule

// File: rtl/display_bus_controller.sv
// CPU-facing register block for the seven-segment display: decodes writes,
// runs a one-bit-per-clock binary-to-BCD conversion and holds the digit word.
module display_bus_controller
  import display_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] address,
  input  logic [31:0] dataout,
  output logic [31:0] rdata,
  output logic [15:0] digits,
  output logic [3:0]  dp_mask,
  output logic        blank,
  output logic        busy,
  output logic        overflow
);

  state_e              state_q, state_d;
  logic [31:0]         value_q, value_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d, step_out;
  logic [3:0]          cnt_q, cnt_d;
  logic                ovf_next_q, ovf_next_d;
  logic [15:0]         digits_q, digits_d;
  logic                overflow_q, overflow_d;
  logic                pending_q, pending_d;

  logic value_we, ctrl_we, req, clamp;
  logic load_en, step_en, commit_en;
  logic [CONV_BITS-1:0] dec_src;

  assign value_we = WE && (address == VALUE_ADDR);
  assign ctrl_we  = WE && (address == CTRL_ADDR);
  // Only a hex_mode flip changes what the display should show.
  assign req      = value_we || (ctrl_we && (dataout[CTRL_HEX] != ctrl_q[CTRL_HEX]));
  assign value_d  = value_we ? dataout : value_q;
  assign ctrl_d   = ctrl_we ? dataout[CTRL_W-1:0] : ctrl_q;

  // Loads use the same-edge write data so a write in IDLE starts immediately.
  assign clamp   = value_d > 32'(DEC_MAX);
  assign dec_src = clamp ? CONV_BITS'(DEC_MAX) : value_d[CONV_BITS-1:0];

  dabble_step u_step (
    .din_i  (shift_q),
    .dout_o (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req || pending_q) state_d = ctrl_d[CTRL_HEX] ? COMMIT : CONV;
      CONV:    if (cnt_q == 4'd1) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    load_en   = (state_q == IDLE) && (req || pending_q);
    step_en   = (state_q == CONV);
    commit_en = (state_q == COMMIT);
  end

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    pending_d  = pending_q;
    if (load_en) begin
      shift_d    = ctrl_d[CTRL_HEX] ? {value_d[15:0], {CONV_BITS{1'b0}}}
                                    : {16'h0000, dec_src};
      cnt_d      = 4'(CONV_BITS);
      ovf_next_d = !ctrl_d[CTRL_HEX] && clamp;
      pending_d  = 1'b0;
    end else if (req && busy) begin
      pending_d  = 1'b1;
    end
    if (step_en) begin
      shift_d = step_out;
      cnt_d   = cnt_q - 4'd1;
    end
    if (commit_en) begin
      digits_d   = shift_q[SHIFT_W-1:CONV_BITS];
      overflow_d = ovf_next_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= '0;
      ctrl_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      value_q    <= value_d;
      ctrl_q     <= ctrl_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      VALUE_ADDR:  rdata = value_q;
      CTRL_ADDR:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      STATUS_ADDR: rdata = {29'b0, pending_q, overflow_q, busy};
      default:     rdata = '0;
    endcase
  end

  assign digits   = digits_q;
  assign dp_mask  = ctrl_q[CTRL_DP_HI:CTRL_DP_LO];
  assign blank    = ctrl_q[CTRL_BLANK];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_display_bus_controller.sv
// Directed bench for display_bus_controller: hand-computed expected values,
// immediate assertions at each comparison point.
module tb_display_bus_controller;

  localparam logic [31:0] A_VALUE  = 32'h0000_0148;
  localparam logic [31:0] A_CTRL   = 32'h0000_014C;
  localparam logic [31:0] A_STATUS = 32'h0000_0150;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WE = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] dataout = '0;
  logic [31:0] rdata;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank, busy, overflow;

  int checks = 0;
  int failures = 0;

  display_bus_controller dut (
    .clk      (clk),
    .rst      (rst),
    .WE       (WE),
    .address  (address),
    .dataout  (dataout),
    .rdata    (rdata),
    .digits   (digits),
    .dp_mask  (dp_mask),
    .blank    (blank),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, rdata, exp);
    address = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1;
    address = a;
    dataout = d;
    tick();
    WE = 1'b0;
    address = '0;
    dataout = '0;
  endtask

  task automatic dec_conv(input string tag, input logic [31:0] v,
                          input logic [15:0] exp_d, input logic exp_o);
    wr(A_VALUE, v);
    repeat (15) tick();
    chk({tag, "_digits"}, 32'(digits), 32'(exp_d));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_o));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset, with a write presented during reset that must be ignored.
    tick();
    WE = 1'b1; address = A_VALUE; dataout = 32'd55;
    tick();
    WE = 1'b0; address = '0; dataout = '0;
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_dp", 32'(dp_mask), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rd_chk("rst_value_rd", A_VALUE, 32'd0);
    rd_chk("rst_status_rd", A_STATUS, 32'd0);
    rst = 1'b0;
    tick();

    // 1234: busy edges N..N+14, result after N+15.
    wr(A_VALUE, 32'd1234);
    chk("c1234_busy_N", 32'(busy), 32'd1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("c1234_busy_N%0d", i), 32'(busy), 32'd1);
      chk($sformatf("c1234_hold_N%0d", i), 32'(digits), 32'd0);
    end
    tick();
    chk("c1234_digits", 32'(digits), 32'h1234);
    chk("c1234_ovf", 32'(overflow), 32'd0);
    chk("c1234_busy_done", 32'(busy), 32'd0);
    rd_chk("c1234_status", A_STATUS, 32'd0);

    // Clamp and boundary values.
    dec_conv("c12345", 32'd12345, 16'h9999, 1'b1);
    rd_chk("c12345_status", A_STATUS, 32'd2);
    dec_conv("c0", 32'd0, 16'h0000, 1'b0);
    dec_conv("c9999", 32'd9999, 16'h9999, 1'b0);
    dec_conv("c10000", 32'd10000, 16'h9999, 1'b1);
    dec_conv("cmax", 32'hFFFF_FFFF, 16'h9999, 1'b1);
    dec_conv("c0b", 32'd0, 16'h0000, 1'b0);

    // 42 at edge N, 7 at edge N+3 -> pending restart.
    wr(A_VALUE, 32'd42);
    tick();
    tick();
    wr(A_VALUE, 32'd7);
    rd_chk("pend_status_set", A_STATUS, 32'd5);
    rd_chk("pend_value_rd", A_VALUE, 32'd7);
    repeat (11) tick();
    chk("pend_hold_N14", 32'(digits), 32'd0);
    tick();
    chk("pend_first_digits", 32'(digits), 32'h0042);
    chk("pend_gap_busy", 32'(busy), 32'd0);
    rd_chk("pend_gap_status", A_STATUS, 32'd4);
    tick();
    chk("pend_restart_busy", 32'(busy), 32'd1);
    rd_chk("pend_restart_status", A_STATUS, 32'd1);
    repeat (14) tick();
    chk("pend_hold2", 32'(digits), 32'h0042);
    chk("pend_busy2", 32'(busy), 32'd1);
    tick();
    chk("pend_second_digits", 32'(digits), 32'h0007);
    chk("pend_done_busy", 32'(busy), 32'd0);
    rd_chk("pend_done_status", A_STATUS, 32'd0);

    // Reset in the middle of a conversion, with ctrl and overflow non-zero.
    dec_conv("c20000", 32'd20000, 16'h9999, 1'b1);
    wr(A_CTRL, 32'h1E);
    chk("ctrl_nochange_busy", 32'(busy), 32'd0);
    chk("ctrl_dp_f", 32'(dp_mask), 32'hF);
    wr(A_VALUE, 32'd1234);
    repeat (5) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_digits", 32'(digits), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_dp", 32'(dp_mask), 32'd0);
    rd_chk("mid_rst_status", A_STATUS, 32'd0);
    rd_chk("mid_rst_ctrl", A_CTRL, 32'd0);
    rd_chk("mid_rst_value", A_VALUE, 32'd0);
    tick();
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);
    chk("mid_rst_idle_digits", 32'(digits), 32'd0);

    // Hex mode and control fields.
    dec_conv("cbeef", 32'h0000_BEEF, 16'h9999, 1'b1);
    wr(A_CTRL, 32'h2B);
    chk("hex_dp", 32'(dp_mask), 32'h5);
    chk("hex_blank", 32'(blank), 32'd1);
    chk("hex_busy", 32'(busy), 32'd1);
    chk("hex_hold", 32'(digits), 32'h9999);
    tick();
    chk("hex_digits", 32'(digits), 32'hBEEF);
    chk("hex_ovf", 32'(overflow), 32'd0);
    chk("hex_busy_done", 32'(busy), 32'd0);
    wr(A_CTRL, 32'h2A);
    chk("dec_back_busy", 32'(busy), 32'd1);
    repeat (14) tick();
    chk("dec_back_hold", 32'(digits), 32'hBEEF);
    tick();
    chk("dec_back_digits", 32'(digits), 32'h9999);
    chk("dec_back_ovf", 32'(overflow), 32'd1);
    wr(A_CTRL, 32'h28);
    chk("dp_only_busy", 32'(busy), 32'd0);
    chk("dp_only_dp", 32'(dp_mask), 32'h4);

    // Unmapped and read-only addresses.
    wr(32'h0000_0144, 32'd5);
    wr(A_STATUS, 32'd7);
    rd_chk("bad_value_rd", A_VALUE, 32'h0000_BEEF);
    rd_chk("bad_144_rd", 32'h0000_0144, 32'd0);
    rd_chk("bad_ctrl_rd", A_CTRL, 32'h28);
    rd_chk("bad_status_rd", A_STATUS, 32'd2);
    chk("bad_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_bus_controller.md
# display_bus_controller

Memory-mapped controller that sits between the CPU data bus and the seven-segment display interface. It decodes CPU writes to three display registers, sequences a multi-cycle iterative binary-to-BCD conversion (double dabble, one bit per clock), and presents a stable 16-bit digit word plus decimal-point and blank controls to the display driver. It replaces the single-cycle combinational converter path and arbitrates between new CPU writes and an in-flight conversion.

## Interface
- VALUE_ADDR, 32'h0000_0148, write address of the value register
- CTRL_ADDR, 32'h0000_014C, write address of the control register
- STATUS_ADDR, 32'h0000_0150, read-only status address
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- WE  in  1  CPU write enable
- address  in  32  CPU byte address
- dataout  in  32  CPU write data
- rdata  out  32  combinational readback for `address`
- digits  out  16  {thousands,hundreds,tens,ones} BCD, or raw hex nibbles
- dp_mask  out  4  decimal point per digit, bit 3 = leftmost
- blank  out  1  1 = display blanked
- busy  out  1  conversion in progress
- overflow  out  1  last decimal conversion was clamped

## Operation
- Registers: value_reg[31:0], ctrl_reg[5:0] = {blank, dp_mask[3:0], hex_mode}; writes accepted when WE=1 and address matches exactly.
- dp_mask/blank outputs are ctrl_reg fields; they update on the edge of the CTRL write, independent of busy.
- Trigger: a VALUE write, or a CTRL write that changes hex_mode, requests a conversion.
- FSM states IDLE, CONV, COMMIT.
  - IDLE + request (or pending=1): load shifter; decimal mode: src = (value > 9999) ? 9999 : value[13:0], ovf_next = (value > 9999); hex mode: skip to COMMIT with digits source value[15:0], ovf_next = 0. Counter = 14, busy=1, go CONV (decimal) or COMMIT (hex). pending cleared.
  - CONV: one step per edge: each BCD nibble >= 5 gets +3, then shift {bcd,bin} left by 1; counter decrements; at counter reaching 0 go COMMIT.
  - COMMIT: digits <= result, overflow <= ovf_next, busy <= 0, go IDLE.
- Request while busy (CONV or COMMIT): value_reg updates immediately, pending <= 1; last write wins; conversion restarts from IDLE with the newest value_reg.
- Request in IDLE on same edge pending is set: single conversion only.
- digits never shows partial results; it changes only in COMMIT.
- rdata: VALUE_ADDR -> value_reg; CTRL_ADDR -> {26'b0, ctrl_reg}; STATUS_ADDR -> {29'b0, pending, overflow, busy}; any other address -> 0.
- Writes to STATUS_ADDR are ignored.

## Timing
- Reset (edge with rst=1): value_reg=0, ctrl_reg=0, digits=16'h0000, dp_mask=0, blank=0, busy=0, overflow=0, pending=0, state IDLE. rst overrides any same-edge write; reset mid-conversion aborts it, digits=0.
- Decimal latency: write accepted at edge N -> busy=1 after N; CONV edges N+1..N+14; digits/overflow valid and busy=0 after edge N+15.
- Hex latency: write at edge N -> digits valid, busy=0 after edge N+1.
- Pending restart: after COMMIT edge M, IDLE loads at edge M+1; back-to-back busy low for exactly one cycle.
- Boundaries: value 9999 -> 16'h9999, overflow 0; 10000 and 32'hFFFF_FFFF -> 16'h9999, overflow 1; value 0 -> 16'h0000.

## Structure
- Package display_ctrl_pkg: address constants, state enum (IDLE, CONV, COMMIT), ctrl bit indices, DEC_MAX=9999, CONV_BITS=14.
- Sub-module dabble_step: combinational one-iteration add-3-and-shift on {bcd[15:0], bin[13:0]}; instantiated once in the CONV path.
- Counter 4 bits; shifter 30 bits.

## Test plan
- Reset with busy mid-conversion -> all outputs 0, state IDLE next cycle, rdata(STATUS)=0.
- Write 1234 to 0x148 at edge N -> busy high N+1..N+15, digits=16'h1234 after N+15, overflow=0.
- Write 12345 -> digits=16'h9999, overflow=1; then write 0 -> digits=16'h0000, overflow=0.
- Write 42 then 7 at 0x148 three cycles apart -> pending=1, digits goes 16'h0042 then 16'h0007, busy low one cycle between.
- Write CTRL=6'b1_0101_1 with value 16'hBEEF -> digits=16'hBEEF after one edge, dp_mask=4'b0101, blank=1; write CTRL hex_mode=0 -> reconversion to clamped 16'h9999.
- Write to 0x144 and 0x150 -> no register change, rdata(0x144)=0.
